// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud timing helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 receiver with mid-bit sampling and a one-entry ready/valid holding register.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

    logic            rx_s;
    rx_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d, data_q, data_d;
    logic            valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
    logic            sym_end, sample_end, sample_bit, stop_hit, deliver, take;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (serial_in),
        .q  (rx_s)
    );

    assign sym_end    = cnt_q == SYM_LAST;
    assign sample_end = cnt_q == SAMPLE_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s) state_d = START;
            START:     if (sample_end) state_d = rx_s ? IDLE : DATA;
            DATA:      if (sym_end && bit_q == 3'd7) state_d = STOP;
            STOP:      if (sym_end) state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_bit = state_q == DATA && sym_end;
        stop_hit   = state_q == STOP && sym_end;
        deliver    = stop_hit && rx_s;
        // A full register still accepts the new byte when the old one leaves this cycle.
        take       = deliver && (!valid_q || data_out_ready);
        cnt_d      = (state_d != state_q || sample_bit) ? '0 : cnt_q + 1'b1;
        bit_d      = state_q != DATA ? 3'd0 : sample_bit ? bit_q + 3'd1 : bit_q;
        shift_d    = sample_bit ? {rx_s, shift_q[7:1]} : shift_q;
        data_d     = take ? shift_q : data_q;
        valid_d    = deliver || (valid_q && !data_out_ready);
        fe_d       = stop_hit && !rx_s;
        ov_d       = deliver && valid_q && !data_out_ready;
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign frame_error    = fe_q;
    assign overrun        = ov_q;

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end that sits directly upstream of `cpu`'s `serial_in` consumer (the memory-stage UART/MMIO path). It synchronises the asynchronous RX pin, detects and validates 8N1 frames at `BAUD_RATE`, and presents each received byte on a single-entry ready/valid holding register. It also flags framing errors and overruns for the MMIO status register.

## Interface
- `CLOCK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
- Derived localparams:
  - `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer, truncating; 434 at defaults).
  - `SAMPLE_TIME = SYMBOL_EDGE_TIME / 2` (217 at defaults).
  - Counter width `$clog2(SYMBOL_EDGE_TIME)`.
- Ports:
  - `clk` in 1: single clock.
  - `rst` in 1: reset, asynchronous, active-high.
  - `serial_in` in 1: asynchronous RX line; idles high.
  - `data_out` out 8: received byte, LSB first on the wire.
  - `data_out_valid` out 1: holding register full.
  - `data_out_ready` in 1: consumer accepts when high with valid.
  - `frame_error` out 1: one-cycle pulse when a stop bit is sampled 0.
  - `overrun` out 1: one-cycle pulse when a completed byte is dropped.

## Operation
- Synchroniser: two flops, both reset to 1. The FSM sees only the second stage (`rx_s`).
- States: IDLE, START, DATA, STOP, WAIT_HIGH. The bit counter resets to 0 on every state entry.
- IDLE:
  - `rx_s==0` → START.
- START:
  - At count `SAMPLE_TIME-1`: if `rx_s==0`, go to DATA; otherwise treat as a glitch and go to IDLE with no output activity.
- DATA:
  - At count `SYMBOL_EDGE_TIME-1`, shift `rx_s` into the shift register MSB (so LSB-first order yields correct `data_out`), clear the count, and increment the bit index.
  - After the 8th sample → STOP.
- STOP, at count `SYMBOL_EDGE_TIME-1`:
  - `rx_s==1`: deliver the byte (see handshake) → IDLE.
  - `rx_s==0`: pulse `frame_error`, discard the byte → WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rx_s==1`, then → IDLE. A held break never produces bytes or repeated errors.
- Handshake / holding register:
  - A transfer occurs on any edge where `data_out_valid && data_out_ready`.
  - `data_out` is stable while valid is high.
  - Delivery when empty, or when full with `data_out_ready` high in the same cycle: load the byte and set valid to 1. In the simultaneous case the old byte transfers and the new one loads, so valid stays 1.
  - Delivery when full and `data_out_ready` low: keep the old byte, drop the new one, pulse `overrun`.
  - Transfer with no delivery: valid → 0.
- Reset (any time, including mid-frame):
  - FSM → IDLE, counters → 0, synchroniser → 1, `data_out` → 0x00.
  - `data_out_valid`, `frame_error`, `overrun` → 0.
  - A partially received byte is discarded.

## Timing
- Number clock edges from 0, where edge 0 is the first edge at which the synchroniser's first flop captures `serial_in` low.
  - FSM enters START at edge 2.
  - Start bit is confirmed at edge `2+SAMPLE_TIME`.
  - Data bit i (0..7) is sampled at edge `2+SAMPLE_TIME+(i+1)*SYMBOL_EDGE_TIME`.
  - Stop bit is sampled at edge `2+SAMPLE_TIME+9*SYMBOL_EDGE_TIME`.
- `data_out_valid`, `frame_error` and `overrun` change in the cycle after the stop sample edge.
- Pulses last exactly 1 cycle.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. The FSM is in IDLE about half a bit before the next falling edge.
- Baud tolerance: sampling is mid-bit, so the block tolerates roughly ±4% total clock mismatch over a frame.
- Outputs are registered. No combinational path runs from `data_out_ready` to any output.

## Structure
- Shared package `uart_pkg`: the state enum (IDLE, START, DATA, STOP, WAIT_HIGH) and a function computing `SYMBOL_EDGE_TIME` from `CLOCK_FREQ`/`BAUD_RATE`. A future `uart_tx` reuses the package.
- One natural sub-module, `sync_2ff` (parameterised reset value, default 1). It is reused for other asynchronous inputs.
- Everything else lives in `uart_rx_frontend`.

## Test plan
- Sim parameters: `CLOCK_FREQ=1000`, `BAUD_RATE=100`, so `SYMBOL_EDGE_TIME=10` and `SAMPLE_TIME=5`. Each bit is driven for 10 cycles.
- Frame 0xA5, `data_out_ready=1` → valid high for exactly 1 cycle, after edge 97, with `data_out=0xA5`. No error pulses.
- `serial_in` low for 3 cycles, then high → FSM returns to IDLE at the start check. Valid, `frame_error` and `overrun` stay 0.
- Frame 0x3C with stop bit 0, line held low 30 more cycles, then a valid 0x55 frame → one `frame_error` pulse, no byte for 0x3C, exactly one byte 0x55.
- `data_out_ready=0`, frames 0x11 then 0x22:
  - `data_out` stays 0x11 with valid high.
  - `overrun` pulses once at the second stop sample.
  - Raising ready → one transfer of 0x11, then valid → 0.
- Consumer asserts `data_out_ready` exactly in the cycle the second byte completes (0x00 then 0xFF) → 0x00 transfers, `data_out` becomes 0xFF, valid stays high, no overrun.
- Assert `rst` mid-DATA of frame 0x81 → all outputs at reset values immediately (asynchronous). After release, frame 0x7E is received correctly as 0x7E.
